// File: rtl/pwm_cap_pkg.sv
// Shared constants and FSM state type for the PWM capture block.
package pwm_cap_pkg;

  localparam int unsigned CNT_W_DEF  = 16;
  localparam int unsigned DUTY_W_DEF = 8;
  localparam int unsigned DIV_ITERS  = DUTY_W_DEF + 1;

  typedef enum logic [1:0] {
    StIdleUnarmed,
    StArmed,
    StDiv
  } state_e;

endpackage

// File: rtl/pwm_cap_div.sv
// Sequential restoring divider: quo = floor(hi * 2^DUTY_W / per), one quotient bit per cycle.
module pwm_cap_div
  import pwm_cap_pkg::*;
#(
  parameter int unsigned CNT_W  = CNT_W_DEF,
  parameter int unsigned DUTY_W = DUTY_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  hi,
  input  logic [CNT_W-1:0]  per,
  output logic              done,
  output logic [DUTY_W:0]   quo
);

  localparam int unsigned QW = DUTY_W + 1;
  localparam int unsigned CW = $clog2(QW + 1);

  logic [CNT_W-1:0] rem_q, den_q, rem_d;
  logic [QW-1:0]    num_q, quo_q, quo_nx;
  logic [CW-1:0]    cnt_q;
  logic [CNT_W:0]   rem_sh;
  logic             ge;

  always_comb begin
    rem_sh = {rem_q, num_q[QW-1]};
    ge     = rem_sh >= {1'b0, den_q};
    // Remainder always stays below the divisor, so it fits back in CNT_W bits.
    rem_d  = CNT_W'(ge ? rem_sh - {1'b0, den_q} : rem_sh);
    quo_nx = QW'({quo_q, ge});
    done   = (cnt_q == CW'(1));
    quo    = quo_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= '0;
      den_q <= '0;
      num_q <= '0;
      quo_q <= '0;
      cnt_q <= '0;
    end else if (start) begin
      // Dividend is hi << DUTY_W; its bits above the quotient span seed the remainder.
      rem_q <= hi >> 1;
      den_q <= per;
      num_q <= {hi[0], {DUTY_W{1'b0}}};
      quo_q <= '0;
      cnt_q <= CW'(QW);
    end else if (cnt_q != '0) begin
      rem_q <= rem_d;
      num_q <= num_q << 1;
      quo_q <= quo_nx;
      cnt_q <= cnt_q - CW'(1);
    end
  end

endmodule

// File: rtl/pwm_capture.sv
// PWM capture and duty-cycle decoder. Optional PWM_CAP_TIMEOUT_EN adds the stuck-input
// detector and the stuck port.
module pwm_capture
  import pwm_cap_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned DUTY_W      = DUTY_W_DEF,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pwm_in,
  output logic [DUTY_W-1:0] duty_out,
  output logic              duty_valid,
  output logic [CNT_W-1:0]  period_out,
  output logic              busy
`ifdef PWM_CAP_TIMEOUT_EN
  ,
  output logic              stuck
`endif
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s, s_q, rise;
  logic [CNT_W-1:0]       per_q, hi_q, p_cap_q, period_q;
  logic [DUTY_W-1:0]      duty_q, duty_sat;
  logic                   valid_q, per_max, start, timeout;
  logic                   div_done;
  logic [DUTY_W:0]        div_quo;
  state_e                 state_q, state_d;

  assign s        = sync_q[SYNC_STAGES-1];
  assign rise     = s & ~s_q;
  assign per_max  = &per_q;
  assign start    = (state_q == StArmed) && rise && !per_max;
  assign duty_sat = div_quo[DUTY_W] ? '1 : div_quo[DUTY_W-1:0];

`ifdef PWM_CAP_TIMEOUT_EN
  assign timeout = (state_q == StArmed) && per_max && !rise;
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdleUnarmed: if (rise) state_d = StArmed;
      StArmed: begin
        if (start)        state_d = StDiv;
        else if (timeout) state_d = StIdleUnarmed;
      end
      StDiv:   if (valid_q) state_d = StArmed;
      default: state_d = StIdleUnarmed;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      s_q     <= 1'b0;
      per_q   <= '0;
      hi_q    <= '0;
      state_q <= StIdleUnarmed;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], pwm_in};
      s_q     <= s;
      state_q <= state_d;
      if (rise) begin
        per_q <= CNT_W'(1);
        hi_q  <= CNT_W'(1);
      end else begin
        if (!per_max)       per_q <= per_q + CNT_W'(1);
        if (s && !(&hi_q))  hi_q  <= hi_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_cap_q  <= '0;
      period_q <= '0;
      duty_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (start) p_cap_q <= per_q;
      if (div_done) begin
        duty_q   <= duty_sat;
        period_q <= p_cap_q;
        valid_q  <= 1'b1;
      end else if (timeout) begin
        duty_q   <= s ? '1 : '0;
        period_q <= '0;
        valid_q  <= 1'b1;
      end
    end
  end

`ifdef PWM_CAP_TIMEOUT_EN
  logic stuck_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       stuck_q <= 1'b0;
    else if (rise)    stuck_q <= 1'b0;
    else if (timeout) stuck_q <= 1'b1;
  end
  assign stuck = stuck_q;
`endif

  pwm_cap_div #(
    .CNT_W  (CNT_W),
    .DUTY_W (DUTY_W)
  ) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .hi    (hi_q),
    .per   (per_q),
    .done  (div_done),
    .quo   (div_quo)
  );

  assign duty_out   = duty_q;
  assign duty_valid = valid_q;
  assign period_out = period_q;
  assign busy       = (state_q == StDiv);

endmodule

// File: doc/pwm_capture.md
# pwm_capture

PWM capture and duty-cycle decoder; the receive-side counterpart of the 8-bit PWM generator. It samples an external PWM waveform on the system clock and measures the period and high time between consecutive rising edges. It then computes an 8-bit duty code equivalent to the generator's compare setting (0–255) and reports each result with a one-cycle valid strobe. It sits between the PWM pin and any logic that needs the received setting: display, loopback check, or a closed-loop compare.

## Interface
- `CNT_W`, default 16: width of the period and high-time counters, in clk cycles.
- `DUTY_W`, default 8: duty code width.
- `SYNC_STAGES`, default 2: input synchronizer depth (minimum 2).
- `clk`  in  1  system clock; every flop is on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `pwm_in`  in  1  external PWM waveform, asynchronous to `clk`.
- `duty_out`  out  DUTY_W  last computed duty code; holds between results.
- `duty_valid`  out  1  one-cycle pulse when `duty_out`/`period_out` update.
- `period_out`  out  CNT_W  last measured period in clk cycles.
- `busy`  out  1  divider running.
- `stuck`  out  1  input static beyond counter range; exists only with `PWM_CAP_TIMEOUT_EN`.

## Operation
- `pwm_in` passes through SYNC_STAGES flops giving `s`. A rising edge `rise` is registered `s` low and current `s` high.
- Counters `per_cnt` and `hi_cnt`:
  - on the `rise` cycle, both load 1;
  - otherwise `per_cnt` increments, saturating at 2^CNT_W−1;
  - `hi_cnt` increments while `s`=1, saturating.
- States:
  - **IDLE_UNARMED** (after reset): the first `rise` arms the block and produces no result.
  - **ARMED**: at each `rise`, capture P=`per_cnt` and H=`hi_cnt` (values before the reload), then go to **DIV**.
  - **DIV**: restoring divide Q = floor(H·2^DUTY_W / P), 9 quotient bits, one bit per cycle. Then `duty_out` = min(Q, 255), `period_out` = P, `duty_valid` pulses, and the state returns to ARMED.
- Boundaries:
  - `per_cnt` saturated at the `rise` cycle: the capture is discarded and the counters restart.
  - `rise` during DIV: that capture is dropped; the counters still reload and the running division completes normally.
  - H=P (no low phase seen): Q=256 is clamped to 255.
  - Reset mid-division: everything returns to reset values; the next `rise` only arms.
- Reset values: `duty_out`=0, `period_out`=0, `duty_valid`=0, `busy`=0, `stuck`=0, state IDLE_UNARMED, counters 0.

## Timing
- Pin-to-`rise` delay: SYNC_STAGES+1 clk cycles.
- With `rise` in cycle E (capture), the timeline is:
  - `busy`=1 in cycles E+1..E+10;
  - `duty_valid`=1 in cycle E+10 only;
  - outputs are updated in cycle E+10 and hold until the next update.
- Minimum period that produces every result is 11 clk cycles. Shorter periods drop alternate captures.

## Configuration
- `PWM_CAP_TIMEOUT_EN` defined:
  - When `per_cnt` reaches saturation, the input is treated as constant.
  - `stuck` is set and one `duty_valid` pulse is issued, with `duty_out`=255 if `s`=1 and 0 if `s`=0, and `period_out`=0.
  - The block is disarmed (IDLE_UNARMED).
  - `stuck` clears on the next `rise`.
- Undefined: the `stuck` port is absent, and a silent input simply produces no further results; the outputs hold.

## Structure
- Shared package `pwm_cap_pkg`:
  - CNT_W/DUTY_W defaults;
  - FSM state enum (IDLE_UNARMED, ARMED, DIV);
  - divider iteration count constant (9).
- One sub-module `pwm_cap_div`: sequential restoring divider with start/done, H and P in, 9-bit Q out. Synchronizer, edge detect, counters and FSM stay at top level.

## Test plan
- Period 256, high 100, steady: the second and later edges give `duty_out`=100 and `period_out`=256 each period, `duty_valid` exactly 10 cycles after `rise`. The first edge gives no result.
- Period 40, high 39: `duty_out`=249. Period 1000, high 500: `duty_out`=128.
- High 255 of 256: `duty_out`=255. Continuous edges with a 1-cycle low phase (H=P−1, P=2) are dropped (P<11 drops alternate captures); the accepted ones produce `duty_out`=128.
- Period 6: only every other capture produces `duty_valid`, and `busy` never overlaps a second division.
- Assert `rst_n` low at E+5 during a division: all outputs are 0 immediately. After release, the first `rise` gives no result and the second gives a correct result.
- With `PWM_CAP_TIMEOUT_EN`, hold `pwm_in`=1 for 70000 cycles: `stuck`=1, one `duty_valid` with `duty_out`=255. Then resume period 256/high 100: `stuck` clears at the first `rise` and the next result is 100.
